// File: rtl/left_shifter_seq_pkg.sv
// left_shifter_seq_pkg: shared shifter types, sizes and stage-amount helper
package left_shifter_seq_pkg;
    localparam int SHIFT_STAGES = 5;
    localparam int SHIFT_W = 32;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    function automatic logic [5:0] stage_amt(input logic [2:0] k);
        return 6'd1 << k;
    endfunction
endpackage

// File: rtl/left_shifter_seq_if.sv
// left_shifter_seq_if: start/done request bus for the shifter (rotate field when LSHIFT_ROTATE_EN)
interface left_shifter_seq_if;
    import left_shifter_seq_pkg::*;
    logic start;
    logic [SHIFT_W-1:0] in;
    logic [4:0] sha;
`ifdef LSHIFT_ROTATE_EN
    logic rotate;
`endif
    logic busy;
    logic done;
    logic [SHIFT_W-1:0] out;
    logic ovf;
    modport master (
        output start, in, sha,
`ifdef LSHIFT_ROTATE_EN
        output rotate,
`endif
        input busy, done, out, ovf
    );
    modport slave (
        input start, in, sha,
`ifdef LSHIFT_ROTATE_EN
        input rotate,
`endif
        output busy, done, out, ovf
    );
endinterface

// File: rtl/left_shifter_seq_lshift_stage.sv
// lshift_stage: one power-of-two left-shift stage (rotate mux only with LSHIFT_ROTATE_EN)
module lshift_stage
    import left_shifter_seq_pkg::*;
(
    input  logic [SHIFT_W-1:0] w,
    input  logic [2:0]         k,
    input  logic               en,
`ifdef LSHIFT_ROTATE_EN
    input  logic               rot,
`endif
    output logic [SHIFT_W-1:0] y,
    output logic               lost
);
    logic [5:0] n;
    logic [SHIFT_W-1:0] sh;
    logic [SHIFT_W-1:0] spill;
    assign n = stage_amt(k);
    assign sh = w << n;
    // spill holds the bits pushed past the MSB, right-aligned
    assign spill = w >> (6'(SHIFT_W) - n);
`ifdef LSHIFT_ROTATE_EN
    assign y = en ? (rot ? (sh | spill) : sh) : w;
    assign lost = en & ~rot & (|spill);
`else
    assign y = en ? sh : w;
    assign lost = en & (|spill);
`endif
endmodule

// File: rtl/left_shifter_seq.sv
// left_shifter_seq: multi-cycle 32-bit left shifter, one stage per clock; rotate mode with LSHIFT_ROTATE_EN
module left_shifter_seq
    import left_shifter_seq_pkg::*;
#(
    parameter int WIDTH = SHIFT_W
) (
    input logic clk,
    input logic rst_n,
    left_shifter_seq_if.slave bus
);
    state_t state, state_n;
    logic [2:0] k, k_n;
    logic [WIDTH-1:0] w, w_n, y, out_r, out_n;
    logic [4:0] sha_r, sha_n;
    logic loss, loss_n, lost, ovf_r, ovf_n, accept;
`ifdef LSHIFT_ROTATE_EN
    logic rot_r, rot_n;
`endif

    lshift_stage u_stage (
        .w(w),
        .k(k),
        .en(sha_r[k]),
`ifdef LSHIFT_ROTATE_EN
        .rot(rot_r),
`endif
        .y(y),
        .lost(lost)
    );

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.out = out_r;
    assign bus.ovf = ovf_r;

    // Register all state; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k <= '0;
            w <= '0;
            sha_r <= '0;
            loss <= 1'b0;
            out_r <= '0;
            ovf_r <= 1'b0;
`ifdef LSHIFT_ROTATE_EN
            rot_r <= 1'b0;
`endif
        end else begin
            state <= state_n;
            k <= k_n;
            w <= w_n;
            sha_r <= sha_n;
            loss <= loss_n;
            out_r <= out_n;
            ovf_r <= ovf_n;
`ifdef LSHIFT_ROTATE_EN
            rot_r <= rot_n;
`endif
        end
    end

    // Accept in IDLE/DONE, step one stage per SHIFT cycle, publish result on the last stage
    always_comb begin
        state_n = state;
        k_n = k;
        w_n = w;
        sha_n = sha_r;
        loss_n = loss;
        out_n = out_r;
        ovf_n = ovf_r;
`ifdef LSHIFT_ROTATE_EN
        rot_n = rot_r;
`endif
        accept = (state != SHIFT) && bus.start;
        if (accept) begin
            state_n = SHIFT;
            k_n = '0;
            w_n = bus.in;
            sha_n = bus.sha;
            loss_n = 1'b0;
`ifdef LSHIFT_ROTATE_EN
            rot_n = bus.rotate;
`endif
        end else if (state == SHIFT) begin
            w_n = y;
            loss_n = loss | lost;
            k_n = k + 3'd1;
            if (k == 3'(SHIFT_STAGES - 1)) begin
                state_n = DONE;
                out_n = y;
                ovf_n = loss | lost;
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
endmodule

// File: tb/tb_left_shifter_seq.sv
// tb_left_shifter_seq: table-driven and sequence checks for left_shifter_seq
module tb_left_shifter_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    left_shifter_seq_if bus();
    left_shifter_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic [31:0] exp_out;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [4:0] s, input logic r);
        bus.in = a;
        bus.sha = s;
`ifdef LSHIFT_ROTATE_EN
        bus.rotate = r;
`else
        if (r) $display("rotate request ignored in logical-only build");
`endif
    endtask

    task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic r, output int lat);
        @(negedge clk);
        drive(a, s, r);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy && bus.done) chk("busy_done_overlap", 32'd1, 32'd0);
        end
    endtask

    initial begin
        int lat, ndone, t, last_t;
        logic [31:0] got_out, prev;
        logic got_ovf, unstable;
        vecs[0]  = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[1]  = '{32'hF000_000F, 5'd4,  32'h0000_00F0, 1'b1};
        vecs[2]  = '{32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
        vecs[3]  = '{32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1'b1};
        vecs[4]  = '{32'h0000_0001, 5'd1,  32'h0000_0002, 1'b0};
        vecs[5]  = '{32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1};
        vecs[6]  = '{32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 1'b0};
        vecs[7]  = '{32'h0001_FFFF, 5'd16, 32'hFFFF_0000, 1'b1};
        vecs[8]  = '{32'hABCD_EF01, 5'd8,  32'hCDEF_0100, 1'b1};
        vecs[9]  = '{32'h0000_0003, 5'd30, 32'hC000_0000, 1'b0};
        vecs[10] = '{32'h0000_0003, 5'd31, 32'h8000_0000, 1'b1};
        bus.start = 1'b0;
        drive(32'h0, 5'd0, 1'b0);
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_out", bus.out, 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].s, 1'b0, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd6);
            chk($sformatf("vec%0d_out", i), bus.out, vecs[i].exp_out);
            chk($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_busy_at_done", i), 32'(bus.busy), 32'd0);
        end

        // second start during SHIFT must be ignored
        @(negedge clk);
        drive(32'h1234_5678, 5'd0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive(32'hFFFF_FFFF, 5'd5, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        got_out = '0;
        got_ovf = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                got_out = bus.out;
                got_ovf = bus.ovf;
            end
        end
        chk("ignore_done_count", 32'(ndone), 32'd1);
        chk("ignore_out", got_out, 32'h1234_5678);
        chk("ignore_ovf", 32'(got_ovf), 32'd0);

        // start held high: three back-to-back requests
        @(negedge clk);
        drive(32'h1, 5'd1, 1'b0);
        bus.start = 1'b1;
        t = 0;
        last_t = 0;
        prev = bus.out;
        unstable = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                t++;
                lat++;
                if (!bus.done && i > 1 && bus.out !== prev) unstable = 1'b1;
            end while (!bus.done && lat < 20);
            chk($sformatf("b2b%0d_out", i), bus.out, 32'h1 << i);
            if (i > 1) chk($sformatf("b2b%0d_gap", i), 32'(t - last_t), 32'd6);
            last_t = t;
            prev = bus.out;
            if (i < 3) bus.sha = 5'(i + 1);
            else bus.start = 1'b0;
        end
        chk("b2b_out_stable", 32'(unstable), 32'd0);

`ifdef LSHIFT_ROTATE_EN
        run_op(32'h8000_0001, 5'd1, 1'b1, lat);
        chk("rot_out", bus.out, 32'h0000_0003);
        chk("rot_ovf", 32'(bus.ovf), 32'd0);
        run_op(32'hF000_000F, 5'd4, 1'b1, lat);
        chk("rot4_out", bus.out, 32'h0000_00FF);
        chk("rot4_ovf", 32'(bus.ovf), 32'd0);
        drive(32'h0, 5'd0, 1'b0);
`endif

        // leave a nonzero out/ovf, then abort mid-SHIFT with reset
        run_op(32'h8000_0001, 5'd1, 1'b0, lat);
        chk("pre_abort_ovf", 32'(bus.ovf), 32'd1);
        @(negedge clk);
        drive(32'h0000_000F, 5'd4, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_out", bus.out, 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
